// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage pipeline: opcodes (shared with
// instruction_decoder), forwarding-select encodings and the scoreboard slot.
package cpu_pipe_pkg;

    // Opcodes as produced/consumed by instruction_decoder.
    localparam logic [5:0] OP_ALU  = 6'b101010;
    localparam logic [5:0] OP_LD   = 6'b100000;
    localparam logic [5:0] OP_SD   = 6'b100001;
    localparam logic [5:0] OP_BEZ  = 6'b100010;
    localparam logic [5:0] OP_BNEZ = 6'b100011;
    localparam logic [5:0] OP_NOP  = 6'b111100;

    // Register address width held in a scoreboard slot (32 GPRs).
    localparam int SB_AW = 5;

    // Operand source selects driven to the ID/EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // One in-flight destination record per downstream stage.
    typedef struct packed {
        logic             wen;
        logic [SB_AW-1:0] rd;
        logic             is_ld;
    } sb_slot_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// Compares one ID read address against the EX/MEM/WB scoreboard slots and
// returns the operand source select plus a load-use hit against EX.
import cpu_pipe_pkg::*;

module hazard_fwd_match (
    input  logic             used,
    input  logic [SB_AW-1:0] addr,
    input  sb_slot_t         ex,
    input  sb_slot_t         mem,
    input  sb_slot_t         wb,
    output logic [1:0]       fwd,
    output logic             ld_hit
);

    // Only EX's is_ld matters; older loads have their data by MEM/WB.
    logic unused_ld_bits;
    assign unused_ld_bits = mem.is_ld ^ wb.is_ld;

    // Nearest-producer search; a load still in EX cannot forward, so it
    // reports a hit (the top stalls) and leaves the select on the regfile.
    always_comb begin
        fwd    = FWD_RF;
        ld_hit = 1'b0;
        if (used) begin
            if (ex.wen && (ex.rd == addr)) begin
                if (ex.is_ld) ld_hit = 1'b1;
                else          fwd    = FWD_EX;
            end else if (mem.wen && (mem.rd == addr)) begin
                fwd = FWD_MEM;
            end else if (wb.wen && (wb.rd == addr)) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing for IF/ID/EX/MEM/WB: tracks in-flight destinations,
// produces stall/bubble/flush/enable controls and operand forwarding selects,
// and counts non-advancing cycles.
import cpu_pipe_pkg::*;

module pipeline_hazard_controller #(
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rA,
    input  logic [REG_AW-1:0]      id_rB,
    input  logic [REG_AW-1:0]      id_rD,
    input  logic                   id_alu,
    input  logic                   id_sfu,
    input  logic                   id_ld,
    input  logic                   id_sd,
    input  logic                   id_bez,
    input  logic                   id_bnez,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   dmem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [1:0]             fwd_d,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Saturating increment for the performance counter.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sb_slot_t   sb_ex, sb_mem, sb_wb, sb_ex_next;
    logic       use_ab, use_d, id_writes;
    logic       freeze, load_use;
    logic       hit_a, hit_b, hit_d;
    logic [1:0] m_fwd_a, m_fwd_b, m_fwd_d;

    // Operand usage by class; an invalid ID slot reads nothing.
    assign use_ab    = id_valid & (id_alu | id_sfu);
    assign use_d     = id_valid & (id_sd | id_bez | id_bnez);
    assign id_writes = id_alu | id_sfu | id_ld;

    assign freeze   = mem_req & ~dmem_ready;
    assign load_use = hit_a | hit_b | hit_d;

    hazard_fwd_match u_match_a (
        .used(use_ab), .addr(SB_AW'(id_rA)), .ex(sb_ex), .mem(sb_mem), .wb(sb_wb),
        .fwd(m_fwd_a), .ld_hit(hit_a)
    );
    hazard_fwd_match u_match_b (
        .used(use_ab), .addr(SB_AW'(id_rB)), .ex(sb_ex), .mem(sb_mem), .wb(sb_wb),
        .fwd(m_fwd_b), .ld_hit(hit_b)
    );
    hazard_fwd_match u_match_d (
        .used(use_d), .addr(SB_AW'(id_rD)), .ex(sb_ex), .mem(sb_mem), .wb(sb_wb),
        .fwd(m_fwd_d), .ld_hit(hit_d)
    );

    // What enters the EX slot: a write only if ID really issues this cycle.
    assign sb_ex_next = {id_valid & id_writes & ~ex_branch_taken & ~load_use,
                         SB_AW'(id_rD), id_ld};

    // Control outputs by priority: reset, freeze, branch squash, load-use.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        fwd_a       = m_fwd_a;
        fwd_b       = m_fwd_b;
        fwd_d       = m_fwd_d;
        if (!reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
            fwd_d       = FWD_RF;
        end else if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Scoreboard shift: clears write enables on reset, holds while frozen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_ex.wen  <= 1'b0;
            sb_mem.wen <= 1'b0;
            sb_wb.wen  <= 1'b0;
        end else if (!freeze) begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= sb_ex_next;
        end
    end

    // Count every cycle in which the PC does not advance.
    always_ff @(posedge clk) begin
        if (!reset)      stall_cycles <= '0;
        else if (!pc_en) stall_cycles <= sat_inc(stall_cycles);
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencing block for the 5-stage CPU pipeline: IF, ID, EX, MEM, WB.
- Consumes the decoded ID-stage instruction fields and keeps a shadow scoreboard of in-flight destination registers for EX, MEM and WB.
- From these it generates stall, bubble, flush and operand-forwarding controls, and freezes the pipeline while the data memory handshake is pending.
- Sits beside instruction_decoder and drives the enables of the pipeline registers and the PC.

Parameters:
- REG_AW, 5, register address width (32 GPRs; R0 is a normal writable register).
- STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low; clock clk
- id_valid  in  1  ID holds a real instruction (decoder nop=1 counts as invalid)
- id_rA, id_rB, id_rD  in  REG_AW each  decoded register addresses
- id_alu, id_sfu, id_ld, id_sd, id_bez, id_bnez  in  1 each  decoded class, one-hot or all-zero
- ex_branch_taken  in  1  EX-stage branch resolved taken this cycle
- mem_req  in  1  MEM stage holds ld/sd issuing to data memory
- dmem_ready  in  1  data memory accepts/completes this cycle
- pc_en  out  1  PC may advance
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_flush  out  1  ID/EX loads bubble
- ex_mem_en, mem_wb_en  out  1 each  later pipe enables
- fwd_a, fwd_b, fwd_d  out  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB data
- stall_cycles  out  STALL_CNT_W  saturating count of non-advancing cycles

Behaviour:
Operand and write rules:
- Reads: alu/sfu read rA and rB; sd and bez/bnez read rD; ld reads none (immediate address).
- Writes: alu, sfu and ld write rD.

Scoreboard:
- Three slots (ex, mem, wb), each {wen, rd, is_ld}.
- Advance on every non-frozen cycle: wb<=mem, mem<=ex, ex<=ID info (wen=0 if ID invalid, stalled or flushed).

Conditions:
- freeze = mem_req & !dmem_ready.
- load_use = id_valid & ex.wen & ex.is_ld & (any read address of the ID instruction == ex.rd).

Priority, highest first:
1. reset.
2. freeze: pc_en, if_id_en, ex_mem_en and mem_wb_en all 0; flushes 0; scoreboard holds.
3. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1; the ID instruction is squashed even if load_use is set.
4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle.
5. Otherwise all enables are 1 and both flushes are 0.

Output timing and forwarding:
- All control outputs are combinational from the current state and inputs; there is zero added latency.
- Forwarding per read operand picks the nearest matching slot with wen=1 in order ex (01), mem (10), wb (11); otherwise 00.
- An ex match with is_ld never forwards; load_use stalls instead.
- Unused operands always select 00.

stall_cycles:
- Increments on any cycle with pc_en=0.
- Saturates at all-ones.

Reset:
- With reset=0 sampled at a clk edge: all scoreboard wen=0, stall_cycles=0.
- While reset=0, outputs are: pc_en=0, if_id_en=0, ex_mem_en=0, mem_wb_en=0, flushes=1, fwd_*=00.
- Asserting reset mid-freeze or mid-stall discards all state.
- The first cycle after reset release is a normal advance.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - opcode localparams (ALU 101010, LD 100000, SD 100001, BEZ 100010, BNEZ 100011, NOP 111100), shared with instruction_decoder;
  - FWD_* 2-bit encodings;
  - the scoreboard-slot struct {wen, rd, is_ld}.
- One sub-module is natural: hazard_fwd_match, the combinational comparator of one read address against three slots, returning the fwd code and the load-use hit. It is instantiated three times.

Test Plan:
1. alu R3 <- R1,R2, then alu R4 <- R3,R5 back-to-back -> second instruction in ID sees fwd_a=01, fwd_b=00, no stall.
2. ld R7, then alu R8 <- R7,R1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle fwd_a=10; stall_cycles=1.
3. sd in MEM with dmem_ready=0 for 3 cycles -> all enables 0 for 3 cycles, scoreboard unchanged, stall_cycles +3; advance resumes when dmem_ready=1.
4. ex_branch_taken=1 while ID holds a load-use dependent instruction -> if_id_flush=1, id_ex_flush=1, pc_en=1, no load-use stall.
5. Three-deep chain writing R9, then bez R9 three cycles later -> fwd_d=11; with R9 also written by a younger instruction now in MEM -> fwd_d=10.
6. reset=0 asserted during a freeze, then released -> stall_cycles=0, fwd_*=00, and the next dependent instruction gets no spurious forward.
